// File: rtl/frame_serializer_tx_if.sv
// frame_serializer_tx_if: payload word port plus chunk output stream
interface frame_serializer_tx_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]  in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [CHUNK_WIDTH-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_sof;
   logic                   out_eof;
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_sof, out_eof
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_sof, out_eof
   );
endinterface

// File: rtl/frame_serializer_tx.sv
// frame_serializer_tx: emits preamble chunks then the payload word MSB-chunk first
module frame_serializer_tx #(
   parameter int                     DATA_WIDTH   = 32,
   parameter int                     CHUNK_WIDTH  = 8,
   parameter int                     NUM_PREAMBLE = 1,
   parameter logic [CHUNK_WIDTH-1:0] PREAMBLE     = CHUNK_WIDTH'(8'hA5)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   frame_serializer_tx_if.slave bus,
   output logic                 busy_o
);
   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int MAX_COUNT  = NUM_CHUNKS > NUM_PREAMBLE ? NUM_CHUNKS : NUM_PREAMBLE;
   localparam int CNT_W      = $clog2(MAX_COUNT) + 1;
   localparam logic [CNT_W-1:0] LAST_PRE = CNT_W'(NUM_PREAMBLE - 1);
   localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  xfer_in, xfer_out;

   // Handshakes and stream outputs decoded from the current state
   always_comb begin
      bus.in_ready  = rst_n && state_q == IDLE;
      bus.out_valid = state_q != IDLE;
      bus.out_data  = state_q == PRE ? PREAMBLE :
                      state_q == PAY ? sr_q[DATA_WIDTH-1 -: CHUNK_WIDTH] : '0;
      bus.out_sof   = cnt_q == '0 && (state_q == PRE || (NUM_PREAMBLE == 0 && state_q == PAY));
      bus.out_eof   = state_q == PAY && cnt_q == LAST_PAY;
      busy_o        = state_q != IDLE;
      xfer_in       = bus.in_valid && bus.in_ready;
      xfer_out      = bus.out_valid && bus.out_ready;
   end

   // Next-state: latch a word in IDLE, count preamble chunks, shift payload out
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (xfer_in) begin
            sr_d    = bus.in_data;
            cnt_d   = '0;
            state_d = NUM_PREAMBLE == 0 ? PAY : PRE;
         end
         PRE: if (xfer_out) begin
            cnt_d   = cnt_q == LAST_PRE ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == LAST_PRE ? PAY : PRE;
         end
         PAY: if (xfer_out) begin
            sr_d    = sr_q << CHUNK_WIDTH;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == LAST_PAY ? IDLE : PAY;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; a low rst_n abandons any frame in progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_frame_serializer_tx.sv
// tb_frame_serializer_tx: queue-based frame model checked every cycle, plus directed literal frames
module tb_frame_serializer_tx;
   typedef struct {logic [31:0] d; bit sof; bit eof;} chunk_t;
   typedef struct {logic [31:0] d; bit sof; bit eof; int cyc;} ent_t;

   localparam logic [31:0] E24 [10] = '{32'hA5, 32'hDE, 32'hAD, 32'hBE, 32'hEF,
                                        32'hA5, 32'h12, 32'h34, 32'h56, 32'h78};
   localparam logic [31:0] E5 [5]   = '{32'hA5, 32'h01, 32'h02, 32'h03, 32'h04};
   localparam logic [31:0] E6 [8]   = '{32'hC, 32'hA, 32'hF, 32'hE, 32'h0, 32'h0, 32'h0, 32'h1};

   logic        clk = 0;
   logic        rst_n;
   logic [31:0] a_data, b_data;
   logic        a_valid, b_valid, a_ordy, b_ordy;
   logic        busy_a, busy_b;
   bit          stall_arm;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   chunk_t      qa[$], qb[$];
   ent_t        loga[$], logb[$];

   frame_serializer_tx_if #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) ifa ();
   frame_serializer_tx_if #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) ifb ();

   assign ifa.in_data   = a_data;
   assign ifa.in_valid  = a_valid;
   assign ifa.out_ready = a_ordy;
   assign ifb.in_data   = b_data;
   assign ifb.in_valid  = b_valid;
   assign ifb.out_ready = b_ordy;

   frame_serializer_tx #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .NUM_PREAMBLE(1), .PREAMBLE(8'hA5)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .busy_o(busy_a));
   frame_serializer_tx #(.DATA_WIDTH(32), .CHUNK_WIDTH(4), .NUM_PREAMBLE(0), .PREAMBLE(4'h0)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .busy_o(busy_b));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input bit b, input logic [31:0] d);
      int     np = b ? 0 : 1;
      int     cw = b ? 4 : 8;
      int     nc = 32 / cw;
      chunk_t c;
      for (int i = 0; i < np; i++) begin
         c.d = 32'hA5; c.sof = (i == 0); c.eof = 0;
         qa.push_back(c);
      end
      for (int j = 0; j < nc; j++) begin
         c.d   = (d >> (32 - (j + 1) * cw)) & ((32'd1 << cw) - 1);
         c.sof = (np == 0 && j == 0);
         c.eof = (j == nc - 1);
         if (b) qb.push_back(c); else qa.push_back(c);
      end
   endtask

   // Model: a frame is a list of chunks; accept when empty, pop one per accepted chunk
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() == 0) begin
            if (a_valid) push(0, a_data);
         end else if (a_ordy) void'(qa.pop_front());
         if (qb.size() == 0) begin
            if (b_valid) push(1, b_data);
         end else if (b_ordy) void'(qb.pop_front());
      end
   end

   // Compare DUT outputs with the model head and log every real output transfer
   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         chk("a_in_ready", 32'(ifa.in_ready), 32'(rst_n && qa.size() == 0));
         chk("a_out_valid", 32'(ifa.out_valid), 32'(qa.size() != 0));
         chk("a_busy", 32'(busy_a), 32'(qa.size() != 0));
         if (qa.size() != 0) begin
            chk("a_out_data", 32'(ifa.out_data), qa[0].d);
            chk("a_sof", 32'(ifa.out_sof), 32'(qa[0].sof));
            chk("a_eof", 32'(ifa.out_eof), 32'(qa[0].eof));
         end else begin
            chk("a_sof_idle", 32'(ifa.out_sof), 0);
            chk("a_eof_idle", 32'(ifa.out_eof), 0);
         end
         chk("b_in_ready", 32'(ifb.in_ready), 32'(rst_n && qb.size() == 0));
         chk("b_out_valid", 32'(ifb.out_valid), 32'(qb.size() != 0));
         chk("b_busy", 32'(busy_b), 32'(qb.size() != 0));
         if (qb.size() != 0) begin
            chk("b_out_data", 32'(ifb.out_data), qb[0].d);
            chk("b_sof", 32'(ifb.out_sof), 32'(qb[0].sof));
            chk("b_eof", 32'(ifb.out_eof), 32'(qb[0].eof));
         end else begin
            chk("b_sof_idle", 32'(ifb.out_sof), 0);
            chk("b_eof_idle", 32'(ifb.out_eof), 0);
         end
         if (rst_n && ifa.out_valid && a_ordy)
            loga.push_back('{32'(ifa.out_data), ifa.out_sof, ifa.out_eof, cyc});
         if (rst_n && ifb.out_valid && b_ordy)
            logb.push_back('{32'(ifb.out_data), ifb.out_sof, ifb.out_eof, cyc});
      end
   end

   // Backpressure injector: three stalled cycles once BE appears
   initial forever begin
      @(posedge clk); #1;
      if (stall_arm && ifa.out_valid && ifa.out_data == 8'hBE) begin
         stall_arm = 0;
         a_ordy = 0;
         repeat (3) @(posedge clk);
         #1 a_ordy = 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_a(input logic [31:0] d);
      int n = 0;
      a_data = d;
      a_valid = 1;
      while (!ifa.in_ready && n < 100) begin @(negedge clk); n++; end
      chk("send_a_timeout", 32'(n < 100), 1);
      @(posedge clk); #1 a_valid = 0;
   endtask

   task automatic wait_eof_a();
      int n = 0;
      do begin @(negedge clk); n++; end while (!(ifa.out_valid && a_ordy && ifa.out_eof) && n < 100);
      chk("eof_a_timeout", 32'(n < 100), 1);
      #1;
   endtask

   initial begin
      int n;
      rst_n = 0; a_valid = 1; a_data = 32'h55; a_ordy = 1;
      b_valid = 0; b_data = 0; b_ordy = 1; stall_arm = 0;
      // T1: reset held with in_valid high
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t1_in_ready", 32'(ifa.in_ready), 0);
      chk("t1_out_valid", 32'(ifa.out_valid), 0);
      chk("t1_busy", 32'(busy_a), 0);
      chk("t1_out_data", 32'(ifa.out_data), 0);
      @(posedge clk); #1 rst_n = 1; a_valid = 0;
      @(negedge clk);
      chk("t1_in_ready_released", 32'(ifa.in_ready), 1);
      chk("t1_no_transfer", loga.size(), 0);
      // T2 + T4: back-to-back frames, second word held during the first
      loga.delete();
      send_a(32'hDEADBEEF);
      a_data = 32'h12345678; a_valid = 1;
      wait_eof_a();
      @(negedge clk);
      chk("t2_in_ready_after_eof", 32'(ifa.in_ready), 1);
      send_a(32'h12345678);
      wait_eof_a();
      chk("t24_count", loga.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < loga.size()) begin
            chk("t24_data", loga[i].d, E24[i]);
            chk("t24_sof", 32'(loga[i].sof), 32'(i % 5 == 0));
            chk("t24_eof", 32'(loga[i].eof), 32'(i % 5 == 4));
         end
      if (loga.size() == 10) begin
         chk("t2_span", loga[4].cyc - loga[0].cyc, 4);
         chk("t4_gap", loga[5].cyc - loga[4].cyc, 2);
      end
      // T3: backpressure on BE
      loga.delete();
      stall_arm = 1;
      send_a(32'hDEADBEEF);
      wait_eof_a();
      chk("t3_stalled", 32'(stall_arm), 0);
      chk("t3_count", loga.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < loga.size()) chk("t3_data", loga[i].d, E24[i]);
      if (loga.size() == 5) chk("t3_span", loga[4].cyc - loga[0].cyc, 7);
      // T5: reset right after AD is transferred
      loga.delete();
      send_a(32'hDEADBEEF);
      n = 0;
      while (loga.size() < 3 && n < 100) begin @(posedge clk); n++; end
      chk("t5_timeout", 32'(n < 100), 1);
      #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      chk("t5_out_valid", 32'(ifa.out_valid), 0);
      chk("t5_busy", 32'(busy_a), 0);
      chk("t5_aborted_count", loga.size(), 3);
      send_a(32'h01020304);
      wait_eof_a();
      chk("t5_count", loga.size(), 8);
      for (int i = 0; i < 5; i++)
         if (i + 3 < loga.size()) chk("t5_data", loga[i + 3].d, E5[i]);
      for (int i = 0; i < loga.size(); i++) chk("t5_eof_only_last", 32'(loga[i].eof), 32'(i == 7));
      // T6: no preamble, 4-bit chunks
      logb.delete();
      b_data = 32'hCAFE0001; b_valid = 1;
      n = 0;
      while (!ifb.in_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1 b_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!(ifb.out_valid && b_ordy && ifb.out_eof) && n < 100);
      #1;
      chk("t6_timeout", 32'(n < 100), 1);
      chk("t6_count", logb.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < logb.size()) begin
            chk("t6_data", logb[i].d, E6[i]);
            chk("t6_sof", 32'(logb[i].sof), 32'(i == 0));
            chk("t6_eof", 32'(logb[i].eof), 32'(i == 7));
         end
      if (logb.size() == 8) chk("t6_span", logb[7].cyc - logb[0].cyc, 7);
      // Random traffic, backpressure and occasional resets on both instances
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         rst_n   = $urandom_range(0, 299) != 0;
         a_valid = 1'($urandom_range(0, 1));
         a_data  = $urandom;
         a_ordy  = $urandom_range(0, 3) != 0;
         b_valid = 1'($urandom_range(0, 1));
         b_data  = $urandom;
         b_ordy  = $urandom_range(0, 3) != 0;
      end
      @(posedge clk); #1 rst_n = 1; a_valid = 0; b_valid = 0; a_ordy = 1; b_ordy = 1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
